// File: rtl/cpu_types_pkg.sv
// ============================================================================
//  Module      : cpu_types_pkg
//  Description : Shared CPU types: machine word and request-unit FSM states.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_types_pkg;

  localparam int unsigned c_WORD_W = 32;

  typedef logic [c_WORD_W-1:0] word_t;

  // Request-unit control states (2-bit encoding)
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DREQ   = 2'd1,
    HALTED = 2'd2
  } ru_state_t;

endpackage

`default_nettype wire

// File: rtl/ll_sc_link.sv
// ============================================================================
//  Module      : ll_sc_link
//  Description : LL/SC link register. Records the address of the last
//                completed load-linked and reports whether a store-conditional
//                to the current address may still succeed.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ll_sc_link
  import cpu_types_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  word_t daddr_i,        // address of the current instruction
  input  logic  snoop_inv_i,    // coherence invalidate this cycle
  input  word_t snoop_addr_i,   // address being invalidated
  input  logic  ll_set_i,       // LL completed this cycle
  input  logic  sc_done_i,      // SC finished (pass or fail) this cycle
  input  logic  store_done_i,   // any store completed this cycle
  output logic  link_match_o    // SC to daddr_i would succeed now
);

  word_t link_addr_q, link_addr_d;
  logic  link_valid_q, link_valid_d;

  logic  w_snoop_hit;
  logic  w_store_hit;

  // A snoop only matters if it targets the currently linked word.
  assign w_snoop_hit = snoop_inv_i & (snoop_addr_i == link_addr_q);
  assign w_store_hit = store_done_i & (daddr_i == link_addr_q);

  // A snoop on the old link wins over a concurrent LL; otherwise LL wins.
  always_comb begin
    link_addr_d  = link_addr_q;
    link_valid_d = link_valid_q;
    if (w_snoop_hit) begin
      link_valid_d = 1'b0;
    end else if (ll_set_i) begin
      link_addr_d  = daddr_i;
      link_valid_d = 1'b1;
    end else if (sc_done_i | w_store_hit) begin
      link_valid_d = 1'b0;
    end
  end

  // Link register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      link_addr_q  <= '0;
      link_valid_q <= 1'b0;
    end else begin
      link_addr_q  <= link_addr_d;
      link_valid_q <= link_valid_d;
    end
  end

  // A snoop arriving in the SC issue cycle also kills the reservation.
  assign link_match_o = link_valid_q & (link_addr_q == daddr_i) & ~w_snoop_hit;

endmodule

`default_nettype wire

// File: rtl/request_unit.sv
// ============================================================================
//  Module      : request_unit
//  Description : Turns decode strobes into held data-cache requests, produces
//                the PC enable, holds the sticky halt and decides LL/SC success.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module request_unit
  import cpu_types_pkg::*;
(
  input  logic  CLK,
  input  logic  RST,
  input  logic  ihit,
  input  logic  dhit,
  input  logic  cu_dREN,
  input  logic  cu_dWEN,
  input  logic  cu_halt,
  input  logic  cu_datomic,
  input  word_t daddr,
  input  logic  snoop_inv,
  input  word_t snoop_addr,
  output logic  imemREN,
  output logic  dmemREN,
  output logic  dmemWEN,
  output logic  pc_en,
  output logic  halt,
  output logic  sc_result
);

  ru_state_t state_q, state_d;
  logic      dren_q, dren_d;
  logic      dwen_q, dwen_d;
  logic      atomic_q, atomic_d;
  logic      sc_result_q, sc_result_d;

  logic      w_pc_en;
  logic      w_ll_set;
  logic      w_sc_done;
  logic      w_store_done;
  logic      w_link_match;
  logic      w_is_sc;

  assign w_is_sc = cu_dWEN & cu_datomic;

  ll_sc_link u_link (
    .clk          (CLK),
    .rst          (RST),
    .daddr_i      (daddr),
    .snoop_inv_i  (snoop_inv),
    .snoop_addr_i (snoop_addr),
    .ll_set_i     (w_ll_set),
    .sc_done_i    (w_sc_done),
    .store_done_i (w_store_done),
    .link_match_o (w_link_match)
  );

  // Next-state, request capture, PC enable and link update strobes.
  always_comb begin
    state_d      = state_q;
    dren_d       = dren_q;
    dwen_d       = dwen_q;
    atomic_d     = atomic_q;
    sc_result_d  = sc_result_q;
    w_pc_en      = 1'b0;
    w_ll_set     = 1'b0;
    w_sc_done    = 1'b0;
    w_store_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (ihit) begin
          if (cu_halt) begin
            state_d = HALTED;
          end else if (cu_dREN | cu_dWEN) begin
            if (w_is_sc & ~w_link_match) begin
              // Failed SC: never reaches the cache, retires immediately.
              sc_result_d = 1'b0;
              w_pc_en     = 1'b1;
              w_sc_done   = 1'b1;
            end else begin
              state_d  = DREQ;
              dren_d   = cu_dREN;
              dwen_d   = cu_dWEN;
              atomic_d = cu_datomic;
              if (w_is_sc) begin
                sc_result_d = 1'b1;
              end
            end
          end else begin
            w_pc_en = 1'b1;
          end
        end
      end
      DREQ: begin
        if (dhit) begin
          state_d      = IDLE;
          dren_d       = 1'b0;
          dwen_d       = 1'b0;
          w_pc_en      = 1'b1;
          w_ll_set     = dren_q & atomic_q;
          w_sc_done    = dwen_q & atomic_q;
          w_store_done = dwen_q;
        end
      end
      HALTED: begin
        dren_d = 1'b0;
        dwen_d = 1'b0;
      end
      default: begin
        state_d = IDLE;
        dren_d  = 1'b0;
        dwen_d  = 1'b0;
      end
    endcase
  end

  // State and request registers; reset drops any pending request.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      dren_q      <= 1'b0;
      dwen_q      <= 1'b0;
      atomic_q    <= 1'b0;
      sc_result_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      dren_q      <= dren_d;
      dwen_q      <= dwen_d;
      atomic_q    <= atomic_d;
      sc_result_q <= sc_result_d;
    end
  end

  assign imemREN   = (state_q != HALTED);
  assign halt      = (state_q == HALTED);
  assign dmemREN   = dren_q;
  assign dmemWEN   = dwen_q;
  assign sc_result = sc_result_q;
  // No PC advance while reset is held, even if a dhit races it.
  assign pc_en     = w_pc_en & ~RST;

endmodule

`default_nettype wire

// File: tb/tb_request_unit.sv
// ============================================================================
//  Module      : tb_request_unit
//  Description : Directed self-checking bench for request_unit.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_request_unit;
  import cpu_types_pkg::*;

  logic  CLK = 1'b0;
  logic  RST, ihit, dhit, cu_dREN, cu_dWEN, cu_halt, cu_datomic, snoop_inv;
  word_t daddr, snoop_addr;
  logic  imemREN, dmemREN, dmemWEN, pc_en, halt, sc_result;

  int checks = 0;
  int errors = 0;

  request_unit dut (
    .CLK        (CLK),
    .RST        (RST),
    .ihit       (ihit),
    .dhit       (dhit),
    .cu_dREN    (cu_dREN),
    .cu_dWEN    (cu_dWEN),
    .cu_halt    (cu_halt),
    .cu_datomic (cu_datomic),
    .daddr      (daddr),
    .snoop_inv  (snoop_inv),
    .snoop_addr (snoop_addr),
    .imemREN    (imemREN),
    .dmemREN    (dmemREN),
    .dmemWEN    (dmemWEN),
    .pc_en      (pc_en),
    .halt       (halt),
    .sc_result  (sc_result)
  );

  always #5 CLK = ~CLK;

  // Advance one cycle; sample point is 1 ns after the rising edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    ihit = 0; dhit = 0; cu_dREN = 0; cu_dWEN = 0; cu_halt = 0;
    cu_datomic = 0; snoop_inv = 0; daddr = '0; snoop_addr = '0;
  endtask

  // Issue a memory op and complete it with dhit on the following cycle.
  task automatic mem_op(input logic ren, input logic wen, input logic atom, input word_t addr);
    ihit = 1; cu_dREN = ren; cu_dWEN = wen; cu_datomic = atom; daddr = addr;
    tick();
    ihit = 0; dhit = 1;
    tick();
    clear_inputs();
  endtask

  task automatic test_reset();
    clear_inputs();
    RST = 1;
    tick(); tick();
    checks++; if (imemREN !== 1'b1) begin errors++; $display("FAIL reset_imemREN: got %b expected 1", imemREN); end
    checks++; if (dmemREN !== 1'b0) begin errors++; $display("FAIL reset_dmemREN: got %b expected 0", dmemREN); end
    checks++; if (dmemWEN !== 1'b0) begin errors++; $display("FAIL reset_dmemWEN: got %b expected 0", dmemWEN); end
    checks++; if (halt !== 1'b0) begin errors++; $display("FAIL reset_halt: got %b expected 0", halt); end
    checks++; if (pc_en !== 1'b0) begin errors++; $display("FAIL reset_pc_en: got %b expected 0", pc_en); end
    checks++; if (sc_result !== 1'b0) begin errors++; $display("FAIL reset_sc_result: got %b expected 0", sc_result); end
    RST = 0;
    #1;
    checks++; if (pc_en !== 1'b0) begin errors++; $display("FAIL idle_no_ihit_pc_en: got %b expected 0", pc_en); end
    ihit = 1;
    #1;
    checks++; if (pc_en !== 1'b1) begin errors++; $display("FAIL alu_pc_en: got %b expected 1", pc_en); end
    tick();
    ihit = 0;
    #1;
    checks++; if (dmemREN !== 1'b0 || dmemWEN !== 1'b0) begin errors++; $display("FAIL alu_no_dreq: got ren=%b wen=%b expected 0 0", dmemREN, dmemWEN); end
    checks++; if (pc_en !== 1'b0) begin errors++; $display("FAIL alu_pc_en_drop: got %b expected 0", pc_en); end
  endtask

  task automatic test_load();
    int cnt_ren = 0;
    int cnt_pc  = 0;
    int pc_cyc  = -1;
    ihit = 1; cu_dREN = 1; daddr = 32'h40;
    #1;
    checks++; if (pc_en !== 1'b0) begin errors++; $display("FAIL load_issue_pc_en: got %b expected 0", pc_en); end
    tick();
    ihit = 0;
    for (int i = 0; i < 6; i++) begin
      dhit = (i == 2);
      #1;
      if (dmemREN) cnt_ren++;
      if (pc_en) begin cnt_pc++; pc_cyc = i; end
      tick();
    end
    clear_inputs();
    checks++; if (cnt_ren !== 3) begin errors++; $display("FAIL load_ren_cycles: got %0d expected 3", cnt_ren); end
    checks++; if (cnt_pc !== 1 || pc_cyc !== 2) begin errors++; $display("FAIL load_pc_en: got count=%0d cyc=%0d expected 1 at 2", cnt_pc, pc_cyc); end
  endtask

  task automatic test_ll_sc();
    mem_op(1'b1, 1'b0, 1'b1, 32'h100);
    ihit = 1; cu_dWEN = 1; cu_datomic = 1; daddr = 32'h100;
    #1;
    checks++; if (pc_en !== 1'b0) begin errors++; $display("FAIL sc1_issue_pc_en: got %b expected 0", pc_en); end
    tick();
    ihit = 0;
    checks++; if (dmemWEN !== 1'b1) begin errors++; $display("FAIL sc1_dmemWEN: got %b expected 1", dmemWEN); end
    checks++; if (sc_result !== 1'b1) begin errors++; $display("FAIL sc1_result: got %b expected 1", sc_result); end
    dhit = 1;
    #1;
    checks++; if (pc_en !== 1'b1) begin errors++; $display("FAIL sc1_dhit_pc_en: got %b expected 1", pc_en); end
    tick();
    clear_inputs();
    checks++; if (dmemWEN !== 1'b0) begin errors++; $display("FAIL sc1_wen_drop: got %b expected 0", dmemWEN); end
    checks++; if (dut.u_link.link_valid_q !== 1'b0) begin errors++; $display("FAIL sc1_link_clear: got %b expected 0", dut.u_link.link_valid_q); end
    ihit = 1; cu_dWEN = 1; cu_datomic = 1; daddr = 32'h100;
    #1;
    checks++; if (pc_en !== 1'b1) begin errors++; $display("FAIL sc2_pc_en: got %b expected 1", pc_en); end
    tick();
    clear_inputs();
    checks++; if (dmemWEN !== 1'b0) begin errors++; $display("FAIL sc2_dmemWEN: got %b expected 0", dmemWEN); end
    checks++; if (sc_result !== 1'b0) begin errors++; $display("FAIL sc2_result: got %b expected 0", sc_result); end
  endtask

  task automatic test_snoop();
    word_t s_addr [3] = '{32'h100, 32'h104, 32'h100};
    logic  s_issue[3] = '{1'b0, 1'b0, 1'b1};
    logic  s_ok   [3] = '{1'b0, 1'b1, 1'b0};
    for (int k = 0; k < 3; k++) begin
      mem_op(1'b1, 1'b0, 1'b1, 32'h100);
      if (!s_issue[k]) begin
        snoop_inv = 1; snoop_addr = s_addr[k];
        tick();
        snoop_inv = 0;
      end
      ihit = 1; cu_dWEN = 1; cu_datomic = 1; daddr = 32'h100;
      if (s_issue[k]) begin snoop_inv = 1; snoop_addr = s_addr[k]; end
      #1;
      checks++; if (pc_en !== !s_ok[k]) begin errors++; $display("FAIL snoop%0d_pc_en: got %b expected %b", k, pc_en, !s_ok[k]); end
      tick();
      ihit = 0; snoop_inv = 0;
      checks++; if (dmemWEN !== s_ok[k]) begin errors++; $display("FAIL snoop%0d_dmemWEN: got %b expected %b", k, dmemWEN, s_ok[k]); end
      checks++; if (sc_result !== s_ok[k]) begin errors++; $display("FAIL snoop%0d_result: got %b expected %b", k, sc_result, s_ok[k]); end
      if (s_ok[k]) begin
        dhit = 1;
        tick();
      end
      clear_inputs();
    end
  endtask

  task automatic test_halt();
    ihit = 1; cu_halt = 1;
    #1;
    checks++; if (pc_en !== 1'b0) begin errors++; $display("FAIL halt_issue_pc_en: got %b expected 0", pc_en); end
    tick();
    clear_inputs();
    checks++; if (halt !== 1'b1) begin errors++; $display("FAIL halt_set: got %b expected 1", halt); end
    checks++; if (imemREN !== 1'b0) begin errors++; $display("FAIL halt_imemREN: got %b expected 0", imemREN); end
    for (int i = 0; i < 4; i++) begin
      ihit = 1; cu_dREN = 1; dhit = i[0];
      #1;
      checks++; if (pc_en !== 1'b0 || halt !== 1'b1) begin errors++; $display("FAIL halted_pc_en%0d: got pc_en=%b halt=%b expected 0 1", i, pc_en, halt); end
      tick();
      checks++; if (dmemREN !== 1'b0 || imemREN !== 1'b0) begin errors++; $display("FAIL halted_req%0d: got ren=%b imem=%b expected 0 0", i, dmemREN, imemREN); end
    end
    clear_inputs();
    RST = 1;
    tick();
    RST = 0;
    checks++; if (halt !== 1'b0 || imemREN !== 1'b1) begin errors++; $display("FAIL halt_exit_rst: got halt=%b imem=%b expected 0 1", halt, imemREN); end
  endtask

  task automatic test_rst_mid_dreq();
    ihit = 1; cu_dWEN = 1; daddr = 32'h200;
    tick();
    ihit = 0;
    checks++; if (dmemWEN !== 1'b1) begin errors++; $display("FAIL rst_store_wen: got %b expected 1", dmemWEN); end
    RST = 1;
    #1;
    checks++; if (pc_en !== 1'b0) begin errors++; $display("FAIL rst_pc_en: got %b expected 0", pc_en); end
    tick();
    RST = 0;
    #1;
    checks++; if (dmemWEN !== 1'b0) begin errors++; $display("FAIL rst_wen_drop: got %b expected 0", dmemWEN); end
    checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL rst_state: got %0d expected %0d", dut.state_q, IDLE); end
    checks++; if (pc_en !== 1'b0) begin errors++; $display("FAIL rst_no_pc_pulse: got %b expected 0", pc_en); end
    clear_inputs();
    tick();
    checks++; if (dmemWEN !== 1'b0) begin errors++; $display("FAIL rst_no_replay: got %b expected 0", dmemWEN); end
  endtask

  initial begin
    RST = 1;
    clear_inputs();
    test_reset();
    test_load();
    test_ll_sc();
    test_snoop();
    test_halt();
    test_rst_mid_dreq();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete within bound");
    $fatal(1);
  end

endmodule

`default_nettype wire
